// File: rtl/csa_accumulator.sv
// Carry-save MAC accumulator: folds one 14-bit term per handshake into a redundant
// (sum, carry) pair and presents it to adder_final after NUM_TERMS terms.
//
// state | meaning
// IDLE  | empty window, term_cnt == 0, accepting terms
// ACC   | partial window, 0 < term_cnt < NUM_TERMS, accepting terms
// HOLD  | completed pair presented on cs_sum/cs_carry, input stalled
module csa_accumulator #(
  parameter int NUM_TERMS = 9,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acc_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [13:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [13:0]      cs_sum,
  output logic [13:0]      cs_carry,
  output logic [CNT_W-1:0] term_cnt
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state_q, state_d;
  logic [13:0]      sum_d, carry_d;
  logic [13:0]      csa_sum, csa_maj;
  logic [CNT_W-1:0] cnt_d;
  logic             out_valid_d, in_ready_d;
  logic             accept, last_term;

  assign accept    = in_valid & in_ready;
  assign last_term = (term_cnt == CNT_W'(NUM_TERMS - 1));

  // Per-column 3:2 compressor; the carry shifts up one column, bit 13 carry-out dropped.
  assign csa_sum = cs_sum ^ cs_carry ^ in_data;
  assign csa_maj = (cs_sum & cs_carry) | (cs_sum & in_data) | (cs_carry & in_data);

  always_comb begin
    state_d     = state_q;
    sum_d       = cs_sum;
    carry_d     = cs_carry;
    cnt_d       = term_cnt;
    out_valid_d = out_valid;
    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          sum_d   = csa_sum;
          carry_d = {csa_maj[12:0], 1'b0};
          cnt_d   = term_cnt + 1'b1;
          if (last_term) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
          end else begin
            state_d = ACC;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          sum_d       = '0;
          carry_d     = '0;
          cnt_d       = '0;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (acc_clr) begin
      state_d     = IDLE;
      sum_d       = '0;
      carry_d     = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end
    in_ready_d = (state_d != HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cs_sum    <= '0;
      cs_carry  <= '0;
      term_cnt  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_sum    <= sum_d;
      cs_carry  <= carry_d;
      term_cnt  <= cnt_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed and random bench for csa_accumulator; resolves the pair as adder_final would
// and compares against a running reference sum of accepted terms.
module tb_csa_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        acc_clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [13:0] cs_sum, cs_carry;
  logic [7:0]  term_cnt;

  int checks = 0;
  int errors = 0;
  logic [13:0] ref_acc;
  logic        mon_en = 1'b0;
  int          windows = 0;

  csa_accumulator #(.NUM_TERMS(9), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .acc_clr(acc_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .cs_sum(cs_sum), .cs_carry(cs_carry), .term_cnt(term_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] resolved();
    return cs_sum + cs_carry;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: sum of terms accepted in the current window, mod 2^14
  always @(posedge clk or negedge reset) begin
    if (!reset)                        ref_acc <= '0;
    else if (acc_clr)                  ref_acc <= '0;
    else if (out_valid && out_ready)   ref_acc <= '0;
    else if (in_valid && in_ready)     ref_acc <= ref_acc + in_data;
  end

  always @(negedge clk) begin
    if (mon_en) chk("invariant", resolved(), ref_acc);
  end

  task automatic send_term(input logic [13:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic take_result(input string tag, input int exp);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_out"}, resolved(), exp);
    chk({tag, "_cnt"}, term_cnt, 9);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drop"}, out_valid, 0);
    chk({tag, "_rdy"}, in_ready, 1);
  endtask

  initial begin
    logic [13:0] s0, c0;
    int n;

    #12;
    chk("rst_sum", cs_sum, 0);
    chk("rst_carry", cs_carry, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    reset = 1'b1;
    tick();
    chk("rst_rel_rdy", in_ready, 1);
    chk("rst_rel_cnt", term_cnt, 0);
    mon_en = 1'b1;

    // T1: nine ones back to back, out_valid on the edge of the 9th accept
    for (int i = 0; i < 9; i++) begin
      send_term(14'd1);
      if (i == 7) chk("t1_early_valid", out_valid, 0);
    end
    chk("t1_latency", out_valid, 1);
    chk("t1_hold_rdy", in_ready, 0);
    take_result("t1", 9);

    // T2: wrap and discarded carry-out
    for (int i = 0; i < 9; i++) send_term(14'h3FFF);
    take_result("t2", 14'h3FF7);

    // T3: gapped terms, long stall with ignored in_valid pulses
    for (int i = 0; i < 9; i++) begin
      n = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) tick();
      send_term(14'(100 + i));
    end
    chk("t3_valid", out_valid, 1);
    s0 = cs_sum;
    c0 = cs_carry;
    for (int i = 0; i < 20; i++) begin
      in_valid = $urandom_range(0, 1);
      in_data  = 14'($urandom_range(0, 16383));
      tick();
      chk("t3_stall_rdy", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("t3_sum_frozen", cs_sum, s0);
    chk("t3_carry_frozen", cs_carry, c0);
    take_result("t3", 936);

    // T4: async reset mid-window
    for (int i = 0; i < 4; i++) send_term(14'd7);
    chk("t4_partial_cnt", term_cnt, 4);
    #3 reset = 1'b0;
    #1;
    chk("t4_sum_clr", cs_sum, 0);
    chk("t4_carry_clr", cs_carry, 0);
    chk("t4_rdy_clr", in_ready, 0);
    chk("t4_cnt_clr", term_cnt, 0);
    #2 reset = 1'b1;
    tick();
    chk("t4_rdy_back", in_ready, 1);
    for (int i = 0; i < 9; i++) send_term(14'd2);
    take_result("t4", 18);

    // T5: acc_clr coincident with the 5th accept drops that term
    for (int i = 0; i < 4; i++) send_term(14'(i + 1));
    acc_clr  = 1'b1;
    in_valid = 1'b1;
    in_data  = 14'd5;
    tick();
    acc_clr  = 1'b0;
    in_valid = 1'b0;
    chk("t5_cnt", term_cnt, 0);
    chk("t5_sum", cs_sum, 0);
    chk("t5_carry", cs_carry, 0);
    chk("t5_valid", out_valid, 0);
    for (int i = 0; i < 9; i++) send_term(14'(i + 1));
    take_result("t5", 45);

    // out_ready while idle has no effect
    send_term(14'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_ready_cnt", term_cnt, 1);
    chk("idle_ready_out", resolved(), 3);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;

    // T6: random traffic; the invariant monitor checks every cycle
    for (int cyc = 0; cyc < 4000; cyc++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      in_data   = 14'($urandom_range(0, 16383));
      out_ready = $urandom_range(0, 2) == 0;
      acc_clr   = $urandom_range(0, 299) == 0;
      if (out_valid) begin
        chk("t6_cnt", term_cnt, 9);
        chk("t6_rdy", in_ready, 0);
        if (out_ready && !acc_clr) windows++;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    acc_clr   = 1'b0;
    tick();
    mon_en = 1'b0;
    if (windows < 50) chk("t6_windows", windows, 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
